// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants and controller state encoding for the RAM
//               controller and the RAM it drives.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int DEFAULT_DEPTH = 9;
  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module      : mem_ctrl
// Description : Turns one CPU-side read/write request into a timed RAM access
//               with configurable wait states and a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic             wr,
  input  logic [DEPTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic [DEPTH-1:0] ram_r_addr,
  output logic [DEPTH-1:0] ram_w_addr,
  output logic [WIDTH-1:0] ram_w_data,
  output logic             ram_wr_en,
  input  logic [WIDTH-1:0] ram_r_data
);

  // With no wait states the counter load value is never used.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]   addr_q, addr_d;
  logic               wr_q, wr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               accept;

  assign accept = (state_q == ST_IDLE) && req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    ram_wr_en = wr_q && (state_q == ST_ACCESS);
  end

  // Request fields are captured only on acceptance; read data only on a read ACCESS.
  always_comb begin
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    if (accept) begin
      addr_d  = addr;
      wr_d    = wr;
      wdata_d = wdata;
      cnt_d   = CNT_LOAD;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q - 1'b1;
    end
    if ((state_q == ST_ACCESS) && !wr_q) begin
      rdata_d = ram_r_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata      = rdata_q;
  assign ram_r_addr = addr_q;
  assign ram_w_addr = addr_q;
  assign ram_w_data = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Self-checking bench for mem_ctrl with 0, 1 and 3 wait states,
//               each instance backed by its own behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic        mem_init;

  logic        req   [3];
  logic [31:0] rdata [3];
  logic        busy  [3];
  logic        done  [3];
  logic [8:0]  raddr [3];
  logic [8:0]  waddr [3];
  logic [31:0] wdat  [3];
  logic        wen   [3];
  logic [31:0] rram  [3];

  logic [31:0] mem [3][512];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.DEPTH(9), .WIDTH(32), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset_n(reset_n), .req(req[0]), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata[0]), .busy(busy[0]), .done(done[0]), .ram_r_addr(raddr[0]),
    .ram_w_addr(waddr[0]), .ram_w_data(wdat[0]), .ram_wr_en(wen[0]), .ram_r_data(rram[0])
  );

  mem_ctrl #(.DEPTH(9), .WIDTH(32), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset_n(reset_n), .req(req[1]), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata[1]), .busy(busy[1]), .done(done[1]), .ram_r_addr(raddr[1]),
    .ram_w_addr(waddr[1]), .ram_w_data(wdat[1]), .ram_wr_en(wen[1]), .ram_r_data(rram[1])
  );

  mem_ctrl #(.DEPTH(9), .WIDTH(32), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset_n(reset_n), .req(req[2]), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata[2]), .busy(busy[2]), .done(done[2]), .ram_r_addr(raddr[2]),
    .ram_w_addr(waddr[2]), .ram_w_data(wdat[2]), .ram_wr_en(wen[2]), .ram_r_data(rram[2])
  );

  // Behavioural RAM: synchronous write, combinational read, known fill pattern.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 512; i++)
          mem[k][i] <= 32'h5A00_0000 | (32'(k) << 16) | 32'(i);
    end else begin
      for (int k = 0; k < 3; k++)
        if (wen[k]) mem[k][waddr[k]] <= wdat[k];
    end
  end

  assign rram[0] = mem[0][raddr[0]];
  assign rram[1] = mem[1][raddr[1]];
  assign rram[2] = mem[2][raddr[2]];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Issue one request on instance k and follow it to its done pulse.
  task automatic do_req(input int k, input logic w, input logic [8:0] a,
                        input logic [31:0] d, input logic scr,
                        output int lat, output int wen_cnt, output int wen_cyc);
    req[k] = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req[k] = 1'b0;
    lat = 0; wen_cnt = 0; wen_cyc = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (wen[k]) begin wen_cnt++; wen_cyc = c; end
      if (scr) begin
        addr = 9'($urandom); wdata = $urandom; wr = 1'($urandom);
      end
      if (done[k]) lat = c;
      else begin @(posedge clk); #1; end
    end
  endtask

  typedef struct {
    int          k;
    logic        w;
    logic [8:0]  a;
    logic [31:0] d;
    logic        scr;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int lat, wcnt, wcyc, prev, ndone;
    logic lastb;

    tbl[0]  = '{1, 1'b1, 9'h005, 32'hDEADBEEF, 1'b0, 32'h0000_0000, 3};
    tbl[1]  = '{1, 1'b0, 9'h005, 32'h0000_0000, 1'b0, 32'hDEADBEEF, 3};
    tbl[2]  = '{1, 1'b1, 9'h006, 32'h1111_1111, 1'b0, 32'hDEADBEEF, 3};
    tbl[3]  = '{1, 1'b0, 9'h006, 32'h0000_0000, 1'b0, 32'h1111_1111, 3};
    tbl[4]  = '{0, 1'b0, 9'h1FF, 32'h0000_0000, 1'b0, 32'h5A00_01FF, 2};
    tbl[5]  = '{2, 1'b0, 9'h1FF, 32'h0000_0000, 1'b0, 32'h5A02_01FF, 5};
    tbl[6]  = '{0, 1'b1, 9'h000, 32'hCAFEF00D, 1'b0, 32'h5A00_01FF, 2};
    tbl[7]  = '{0, 1'b0, 9'h000, 32'h0000_0000, 1'b0, 32'hCAFEF00D, 2};
    tbl[8]  = '{2, 1'b1, 9'h1FF, 32'h0BADF00D, 1'b0, 32'h5A02_01FF, 5};
    tbl[9]  = '{2, 1'b0, 9'h1FF, 32'h0000_0000, 1'b0, 32'h0BADF00D, 5};
    tbl[10] = '{1, 1'b1, 9'h020, 32'hAAAA5555, 1'b1, 32'h1111_1111, 3};
    tbl[11] = '{1, 1'b0, 9'h020, 32'h0000_0000, 1'b1, 32'hAAAA5555, 3};

    // Reset held with req asserted: everything stays quiet.
    reset_n = 1'b0; mem_init = 1'b1; wr = 1'b1; addr = 9'h0AA; wdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) req[k] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        chk("rst_busy",  32'(busy[k]), 32'd0);
        chk("rst_done",  32'(done[k]), 32'd0);
        chk("rst_rdata", rdata[k],     32'd0);
        chk("rst_wr_en", 32'(wen[k]),  32'd0);
      end
    end
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    mem_init = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      do_req(tbl[i].k, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].scr, lat, wcnt, wcyc);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), rdata[tbl[i].k], tbl[i].exp_rdata);
      chk($sformatf("v%0d_wr_en_count", i), 32'(wcnt), tbl[i].w ? 32'd1 : 32'd0);
      if (tbl[i].w) begin
        chk($sformatf("v%0d_wr_en_cycle", i), 32'(wcyc), 32'(ws_of(tbl[i].k) + 1));
        chk($sformatf("v%0d_ram_word", i), mem[tbl[i].k][tbl[i].a], tbl[i].d);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_width", i), 32'(done[tbl[i].k]), 32'd0);
      chk($sformatf("v%0d_busy_end", i), 32'(busy[tbl[i].k]), 32'd0);
    end

    // Continuous req: accepts are spaced WAIT_STATES+3 cycles apart.
    for (int k = 0; k < 3; k += 2) begin
      req[k] = 1'b1; wr = 1'b0; addr = 9'h1FF;
      prev = -1; lastb = busy[k];
      for (int c = 0; c < 24; c++) begin
        @(posedge clk); #1;
        if (busy[k] && !lastb) begin
          if (prev >= 0) chk($sformatf("spacing_ws%0d", ws_of(k)), 32'(c - prev), 32'(ws_of(k) + 3));
          prev = c;
        end
        lastb = busy[k];
      end
      req[k] = 1'b0;
      for (int c = 0; c < 10 && busy[k]; c++) begin @(posedge clk); #1; end
      chk($sformatf("spacing_idle_ws%0d", ws_of(k)), 32'(busy[k]), 32'd0);
    end

    // Write aborted by reset during its 2nd WAIT cycle.
    req[2] = 1'b1; wr = 1'b1; addr = 9'h010; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_before", 32'(busy[2]), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy",  32'(busy[2]), 32'd0);
    chk("abort_wr_en", 32'(wen[2]),  32'd0);
    chk("abort_rdata", rdata[2],     32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (done[2] || wen[2]) ndone++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_ram_word", mem[2][9'h010], 32'h5A02_0010);
    do_req(2, 1'b0, 9'h010, 32'h0, 1'b0, lat, wcnt, wcyc);
    chk("abort_read_latency", 32'(lat), 32'd5);
    chk("abort_read_rdata", rdata[2], 32'h5A02_0010);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
